// File: rtl/param_datapath_iter.sv
// Single-bus Mini SRC datapath: register file, special registers, encoded bus source
// select and an ALU whose MUL/DIV iterate one bit per cycle behind a start/busy/done handshake.
module param_datapath_iter #(
    parameter int WIDTH  = 32,
    parameter int NREGS  = 16,
    parameter int MEM_AW = 9,
    localparam int SW    = $clog2(NREGS + 8),
    localparam int RW    = $clog2(NREGS)
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic [SW-1:0]     Bus_Src,
    input  logic              BA_Out,
    input  logic              Reg_We,
    input  logic [RW-1:0]     Reg_Waddr,
    input  logic              PC_In,
    input  logic              IncPC,
    input  logic              IR_In,
    input  logic              MAR_In,
    input  logic              MDR_In,
    input  logic              Read,
    input  logic              Y_In,
    input  logic              HI_In,
    input  logic              LO_In,
    input  logic              InPort_In,
    input  logic              OutPort_In,
    input  logic [3:0]        Alu_Op,
    input  logic              Alu_Start,
    input  logic [WIDTH-1:0]  Input_Data,
    input  logic [WIDTH-1:0]  RAM_Data,
    output logic [WIDTH-1:0]  BusMux_Out,
    output logic [WIDTH-1:0]  IR_Data,
    output logic [MEM_AW-1:0] MAR_Data,
    output logic [WIDTH-1:0]  MDR_Data,
    output logic [WIDTH-1:0]  Output_Data,
    output logic              Alu_Busy,
    output logic              Alu_Done,
    output logic              Div_By_Zero
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SHR = 4'd2;
    localparam logic [3:0] OP_SHL = 4'd3;
    localparam logic [3:0] OP_ROR = 4'd4;
    localparam logic [3:0] OP_ROL = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;
    localparam logic [3:0] OP_NEG = 4'd10;
    localparam logic [3:0] OP_NOT = 4'd11;

    typedef enum logic {IDLE, RUN} state_t;

    logic [WIDTH-1:0]  regs_q [NREGS];
    logic [WIDTH-1:0]  regs_d [NREGS];
    logic [WIDTH-1:0]  pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
    logic [WIDTH-1:0]  hi_q, hi_d, lo_q, lo_d, y_q, y_d;
    logic [WIDTH-1:0]  zhi_q, zhi_d, zlo_q, zlo_d;
    logic [WIDTH-1:0]  inport_q, inport_d, outport_q, outport_d;
    logic [MEM_AW-1:0] mar_q, mar_d;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d, op_b_q, op_b_d, mag_b_q, mag_b_d;
    logic [WIDTH-1:0]  work_hi_q, work_hi_d, work_lo_q, work_lo_d;
    logic              is_div_q, is_div_d, done_q, done_d, dbz_q, dbz_d;

    logic [WIDTH-1:0]  bus;
    logic [WIDTH-1:0]  c_ext;
    logic [CW-1:0]     shamt;
    logic [WIDTH-1:0]  alu_res;
    logic [WIDTH-1:0]  y_mag, bus_mag;
    logic [WIDTH:0]    mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0]  mul_hi_nx, mul_lo_nx, div_hi_nx, div_lo_nx;
    logic [2*WIDTH-1:0] mul_mag, mul_fin;
    logic [WIDTH-1:0]  div_q_fin, div_r_fin;

    assign c_ext = {{(WIDTH-19){ir_q[18]}}, ir_q[18:0]};

    always_comb begin
        bus = '0;
        if (int'(Bus_Src) < NREGS) begin
            if (!(Bus_Src == '0 && BA_Out)) begin
                bus = regs_q[Bus_Src[RW-1:0]];
            end
        end else begin
            case (int'(Bus_Src) - NREGS)
                0:       bus = hi_q;
                1:       bus = lo_q;
                2:       bus = zhi_q;
                3:       bus = zlo_q;
                4:       bus = pc_q;
                5:       bus = mdr_q;
                6:       bus = inport_q;
                7:       bus = c_ext;
                default: bus = '0;
            endcase
        end
    end

    always_comb begin
        regs_d    = regs_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        mar_d     = mar_q;
        mdr_d     = mdr_q;
        y_d       = y_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        inport_d  = inport_q;
        outport_d = outport_q;
        if (Reg_We && (int'(Reg_Waddr) < NREGS)) regs_d[Reg_Waddr] = bus;
        if (PC_In)       pc_d = bus;
        else if (IncPC)  pc_d = pc_q + 1'b1;
        if (IR_In)       ir_d = bus;
        if (MAR_In)      mar_d = bus[MEM_AW-1:0];
        if (MDR_In)      mdr_d = Read ? RAM_Data : bus;
        if (Y_In)        y_d = bus;
        if (HI_In)       hi_d = bus;
        if (LO_In)       lo_d = bus;
        if (InPort_In)   inport_d = Input_Data;
        if (OutPort_In)  outport_d = bus;
    end

    // Single-cycle ops: A is Y, B is the live bus value.
    always_comb begin
        shamt   = bus[CW-1:0];
        alu_res = '0;
        case (Alu_Op)
            OP_ADD:  alu_res = y_q + bus;
            OP_SUB:  alu_res = y_q - bus;
            OP_SHR:  alu_res = y_q >> shamt;
            OP_SHL:  alu_res = y_q << shamt;
            OP_ROR:  alu_res = (y_q >> shamt) | (y_q << (WIDTH - int'(shamt)));
            OP_ROL:  alu_res = (y_q << shamt) | (y_q >> (WIDTH - int'(shamt)));
            OP_AND:  alu_res = y_q & bus;
            OP_OR:   alu_res = y_q | bus;
            OP_NEG:  alu_res = -bus;
            OP_NOT:  alu_res = ~bus;
            default: alu_res = '0;
        endcase
    end

    // MUL and DIV iterate on magnitudes; signs are applied when the last bit retires.
    always_comb begin
        y_mag     = y_q[WIDTH-1] ? -y_q : y_q;
        bus_mag   = bus[WIDTH-1] ? -bus : bus;

        mul_sum   = {1'b0, work_hi_q} + {1'b0, (work_lo_q[0] ? mag_b_q : '0)};
        mul_hi_nx = mul_sum[WIDTH:1];
        mul_lo_nx = {mul_sum[0], work_lo_q[WIDTH-1:1]};

        div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_b_q};
        div_hi_nx = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        div_lo_nx = {work_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};

        mul_mag   = {mul_hi_nx, mul_lo_nx};
        mul_fin   = (op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1]) ? -mul_mag : mul_mag;
        div_q_fin = (op_a_q[WIDTH-1] ^ op_b_q[WIDTH-1]) ? -div_lo_nx : div_lo_nx;
        div_r_fin = op_a_q[WIDTH-1] ? -div_hi_nx : div_hi_nx;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        mag_b_d   = mag_b_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        is_div_d  = is_div_q;
        zhi_d     = zhi_q;
        zlo_d     = zlo_q;
        done_d    = 1'b0;
        dbz_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (Alu_Start) begin
                    if (Alu_Op == OP_MUL || Alu_Op == OP_DIV) begin
                        state_d   = RUN;
                        cnt_d     = '0;
                        op_a_d    = y_q;
                        op_b_d    = bus;
                        mag_b_d   = bus_mag;
                        work_hi_d = '0;
                        work_lo_d = y_mag;
                        is_div_d  = (Alu_Op == OP_DIV);
                    end else begin
                        zhi_d  = '0;
                        zlo_d  = alu_res;
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                cnt_d     = cnt_q + 1'b1;
                work_hi_d = is_div_q ? div_hi_nx : mul_hi_nx;
                work_lo_d = is_div_q ? div_lo_nx : mul_lo_nx;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (!is_div_q) begin
                        {zhi_d, zlo_d} = mul_fin;
                    end else if (op_b_q == '0) begin
                        zhi_d = op_a_q;
                        zlo_d = '1;
                        dbz_d = 1'b1;
                    end else begin
                        zhi_d = div_r_fin;
                        zlo_d = div_q_fin;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            pc_q      <= '0;
            ir_q      <= '0;
            mar_q     <= '0;
            mdr_q     <= '0;
            y_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            zhi_q     <= '0;
            zlo_q     <= '0;
            inport_q  <= '0;
            outport_q <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            mag_b_q   <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            is_div_q  <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mar_q     <= mar_d;
            mdr_q     <= mdr_d;
            y_q       <= y_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            zhi_q     <= zhi_d;
            zlo_q     <= zlo_d;
            inport_q  <= inport_d;
            outport_q <= outport_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            mag_b_q   <= mag_b_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            is_div_q  <= is_div_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign BusMux_Out  = bus;
    assign IR_Data     = ir_q;
    assign MAR_Data    = mar_q;
    assign MDR_Data    = mdr_q;
    assign Output_Data = outport_q;
    assign Alu_Busy    = (state_q == RUN);
    assign Alu_Done    = done_q;
    assign Div_By_Zero = dbz_q;

endmodule

// File: tb/tb_param_datapath_iter.sv
// Bench for param_datapath_iter: directed steps with a scoreboard of expected ALU
// results pushed at start and popped when Alu_Done is seen.
module tb_param_datapath_iter;

    localparam int W   = 32;
    localparam int N   = 16;
    localparam int AW  = 9;
    localparam int SWB = 5;
    localparam int RWB = 4;

    localparam int SRC_HI  = N + 0;
    localparam int SRC_ZHI = N + 2;
    localparam int SRC_ZLO = N + 3;
    localparam int SRC_PC  = N + 4;
    localparam int SRC_IN  = N + 6;
    localparam int SRC_C   = N + 7;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SHR = 4'd2, OP_SHL = 4'd3;
    localparam logic [3:0] OP_ROR = 4'd4, OP_ROL = 4'd5, OP_AND = 4'd6, OP_OR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8, OP_DIV = 4'd9, OP_NEG = 4'd10, OP_NOT = 4'd11;

    logic           Clock, Clear, BA_Out, Reg_We;
    logic [SWB-1:0] Bus_Src;
    logic [RWB-1:0] Reg_Waddr;
    logic           PC_In, IncPC, IR_In, MAR_In, MDR_In, Read, Y_In, HI_In, LO_In;
    logic           InPort_In, OutPort_In, Alu_Start;
    logic [3:0]     Alu_Op;
    logic [W-1:0]   Input_Data, RAM_Data;
    logic [W-1:0]   BusMux_Out, IR_Data, MDR_Data, Output_Data;
    logic [AW-1:0]  MAR_Data;
    logic           Alu_Busy, Alu_Done, Div_By_Zero;

    typedef struct {
        logic [63:0] z;
        logic        dbz;
        int          lat;
        int          busy;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    param_datapath_iter #(.WIDTH(W), .NREGS(N), .MEM_AW(AW)) dut (
        .Clock(Clock), .Clear(Clear), .Bus_Src(Bus_Src), .BA_Out(BA_Out),
        .Reg_We(Reg_We), .Reg_Waddr(Reg_Waddr), .PC_In(PC_In), .IncPC(IncPC),
        .IR_In(IR_In), .MAR_In(MAR_In), .MDR_In(MDR_In), .Read(Read), .Y_In(Y_In),
        .HI_In(HI_In), .LO_In(LO_In), .InPort_In(InPort_In), .OutPort_In(OutPort_In),
        .Alu_Op(Alu_Op), .Alu_Start(Alu_Start), .Input_Data(Input_Data),
        .RAM_Data(RAM_Data), .BusMux_Out(BusMux_Out), .IR_Data(IR_Data),
        .MAR_Data(MAR_Data), .MDR_Data(MDR_Data), .Output_Data(Output_Data),
        .Alu_Busy(Alu_Busy), .Alu_Done(Alu_Done), .Div_By_Zero(Div_By_Zero)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [31:0] r;
        logic signed [63:0] p;
        logic signed [31:0] da, db, q, rm;
        int s;
        e.dbz = 1'b0; e.lat = 1; e.busy = 0; r = '0; s = int'(b[4:0]);
        da = a; db = b;
        case (op)
            OP_ADD: r = a + b;
            OP_SUB: r = a - b;
            OP_SHR: r = a >> s;
            OP_SHL: r = a << s;
            OP_ROR: begin r = a; for (int i = 0; i < s; i++) r = {r[0], r[31:1]}; end
            OP_ROL: begin r = a; for (int i = 0; i < s; i++) r = {r[30:0], r[31]}; end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_NEG: r = 32'd0 - b;
            OP_NOT: r = ~b;
            default: r = '0;
        endcase
        e.z = {32'h0, r};
        if (op == OP_MUL) begin
            p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            e.z = p; e.lat = W + 1; e.busy = W;
        end else if (op == OP_DIV) begin
            e.lat = W + 1; e.busy = W;
            if (b == 32'h0) begin
                e.z = {a, 32'hFFFF_FFFF}; e.dbz = 1'b1;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.z = {32'h0, 32'h8000_0000};
            end else begin
                q = da / db; rm = da % db;
                e.z = {rm, q};
            end
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic loadIn(input logic [31:0] v);
        Input_Data = v; InPort_In = 1'b1; tick(); InPort_In = 1'b0;
    endtask

    task automatic loadReg(input int idx, input logic [31:0] v);
        loadIn(v);
        Bus_Src = SWB'(SRC_IN); Reg_Waddr = RWB'(idx); Reg_We = 1'b1; tick(); Reg_We = 1'b0;
    endtask

    task automatic loadY(input logic [31:0] v);
        loadIn(v);
        Bus_Src = SWB'(SRC_IN); Y_In = 1'b1; tick(); Y_In = 1'b0;
    endtask

    // A goes through Y, B is parked in R3 and driven onto the bus for the start cycle.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        loadReg(3, b);
        loadY(a);
        Bus_Src = SWB'(3); BA_Out = 1'b0; Alu_Op = op; Alu_Start = 1'b1;
        sb.push_back(model(op, a, b));
        tick();
        Alu_Start = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int pulse_at);
        exp_t e;
        int lat, busy;
        logic [31:0] zhi, zlo;
        lat = 1; busy = 0;
        while (Alu_Done !== 1'b1 && lat < 80) begin
            if (Alu_Busy === 1'b1) busy++;
            if (lat == pulse_at) begin
                Bus_Src = SWB'(5); Y_In = 1'b1; Alu_Op = OP_MUL; Alu_Start = 1'b1;
            end
            tick();
            Y_In = 1'b0; Alu_Start = 1'b0;
            lat++;
        end
        if (sb.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        checkOutput({tag, "_latency"}, 64'(lat), 64'(e.lat));
        checkOutput({tag, "_busy_cycles"}, 64'(busy), 64'(e.busy));
        checkOutput({tag, "_busy_at_done"}, 64'(Alu_Busy), 64'd0);
        checkOutput({tag, "_div_by_zero"}, 64'(Div_By_Zero), 64'(e.dbz));
        Bus_Src = SWB'(SRC_ZHI); #1 zhi = BusMux_Out;
        Bus_Src = SWB'(SRC_ZLO); #1 zlo = BusMux_Out;
        checkOutput({tag, "_z"}, {zhi, zlo}, e.z);
        tick();
        checkOutput({tag, "_done_pulse"}, 64'(Alu_Done), 64'd0);
    endtask

    initial begin
        int extra_done;
        Clear = 1'b0; Bus_Src = '0; BA_Out = 1'b0; Reg_We = 1'b0; Reg_Waddr = '0;
        PC_In = 1'b0; IncPC = 1'b0; IR_In = 1'b0; MAR_In = 1'b0; MDR_In = 1'b0;
        Read = 1'b0; Y_In = 1'b0; HI_In = 1'b0; LO_In = 1'b0; InPort_In = 1'b0;
        OutPort_In = 1'b0; Alu_Start = 1'b0; Alu_Op = '0; Input_Data = '0; RAM_Data = '0;
        tick(); tick();
        $display("[TB] reset state");
        checkOutput("rst_busy", 64'(Alu_Busy), 64'd0);
        checkOutput("rst_done", 64'(Alu_Done), 64'd0);
        checkOutput("rst_dbz", 64'(Div_By_Zero), 64'd0);
        checkOutput("rst_ir", 64'(IR_Data), 64'd0);
        checkOutput("rst_out", 64'(Output_Data), 64'd0);
        Bus_Src = SWB'(SRC_ZLO); #1;
        checkOutput("rst_zlo", 64'(BusMux_Out), 64'd0);
        Clear = 1'b1;
        tick();

        $display("[TB] single-cycle ops");
        applyStimulus(OP_ADD, 32'd7, 32'd5);                   waitDone("add", 0);
        applyStimulus(OP_SUB, 32'd3, 32'd10);                  waitDone("sub", 0);
        applyStimulus(OP_SHR, 32'h8000_0000, 32'h0000_0024);   waitDone("shr", 0);
        applyStimulus(OP_SHL, 32'h0000_00F1, 32'd28);          waitDone("shl", 0);
        applyStimulus(OP_ROR, 32'h1234_5678, 32'd8);           waitDone("ror", 0);
        applyStimulus(OP_ROL, 32'h8765_4321, 32'd0);           waitDone("rol0", 0);
        applyStimulus(OP_ROL, 32'h8765_4321, 32'd12);          waitDone("rol", 0);
        applyStimulus(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);   waitDone("and", 0);
        applyStimulus(OP_OR,  32'hF000_0000, 32'h0000_000F);   waitDone("or", 0);
        applyStimulus(OP_NEG, 32'hDEAD_BEEF, 32'd1);           waitDone("neg", 0);
        applyStimulus(OP_NOT, 32'h1, 32'h0F0F_0F0F);           waitDone("not", 0);
        applyStimulus(4'd13,  32'h5, 32'h6);                   waitDone("op13", 0);

        $display("[TB] multi-cycle ops");
        applyStimulus(OP_MUL, 32'hFFFF_FFFD, 32'h7FFF_FFFF);   waitDone("mul", 0);
        applyStimulus(OP_MUL, 32'h8000_0000, 32'h8000_0000);   waitDone("mul_min", 0);
        applyStimulus(OP_MUL, $urandom, $urandom);             waitDone("mul_rand", 0);
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);           waitDone("div", 0);
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd0);           waitDone("div_zero", 0);
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);   waitDone("div_ovf", 0);
        applyStimulus(OP_DIV, 32'd100, 32'hFFFF_FFF9);         waitDone("div_negb", 0);
        applyStimulus(OP_DIV, $urandom, 32'(1 + $urandom_range(0, 1000))); waitDone("div_rand", 0);

        $display("[TB] start ignored while running");
        loadReg(5, 32'h0000_1111);
        applyStimulus(OP_MUL, 32'h0000_1234, 32'hFFFF_FFFB);
        waitDone("mul_restart", 5);
        extra_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (Alu_Done === 1'b1) extra_done++;
            tick();
        end
        checkOutput("restart_extra_done", 64'(extra_done), 64'd0);

        $display("[TB] reset during run");
        applyStimulus(OP_MUL, 32'h0000_0003, 32'h0000_0005);
        for (int i = 1; i < 10; i++) tick();
        Bus_Src = SWB'(SRC_ZLO);
        Clear = 1'b0; #1;
        checkOutput("abort_busy", 64'(Alu_Busy), 64'd0);
        checkOutput("abort_done", 64'(Alu_Done), 64'd0);
        checkOutput("abort_zlo", 64'(BusMux_Out), 64'd0);
        void'(sb.pop_front());
        #2 Clear = 1'b1;
        tick();
        extra_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (Alu_Done === 1'b1) extra_done++;
            tick();
        end
        checkOutput("abort_no_done", 64'(extra_done), 64'd0);
        applyStimulus(OP_MUL, 32'h0000_0003, 32'hFFFF_FFFE);   waitDone("mul_after_abort", 0);

        $display("[TB] bus sources and register loads");
        loadReg(0, 32'h55);
        Bus_Src = SWB'(0); BA_Out = 1'b1; #1;
        checkOutput("r0_zeroed", 64'(BusMux_Out), 64'd0);
        BA_Out = 1'b0; #1;
        checkOutput("r0_value", 64'(BusMux_Out), 64'h55);
        loadIn(32'h0004_0000);
        Bus_Src = SWB'(SRC_IN); IR_In = 1'b1; tick(); IR_In = 1'b0;
        checkOutput("ir_load", 64'(IR_Data), 64'h0004_0000);
        Bus_Src = SWB'(SRC_C); #1;
        checkOutput("c_sext", 64'(BusMux_Out), 64'hFFFC_0000);
        Bus_Src = SWB'(N + 8); #1;
        checkOutput("src_oor", 64'(BusMux_Out), 64'd0);
        Bus_Src = SWB'(31); #1;
        checkOutput("src_oor_max", 64'(BusMux_Out), 64'd0);

        loadIn(32'h0000_1234);
        Bus_Src = SWB'(SRC_IN); PC_In = 1'b1; IncPC = 1'b1; tick(); PC_In = 1'b0;
        Bus_Src = SWB'(SRC_PC); #1;
        checkOutput("pc_priority", 64'(BusMux_Out), 64'h1234);
        tick(); IncPC = 1'b0; #1;
        checkOutput("pc_inc", 64'(BusMux_Out), 64'h1235);
        loadIn(32'hFFFF_FFFF);
        Bus_Src = SWB'(SRC_IN); PC_In = 1'b1; tick(); PC_In = 1'b0;
        IncPC = 1'b1; tick(); IncPC = 1'b0;
        Bus_Src = SWB'(SRC_PC); #1;
        checkOutput("pc_wrap", 64'(BusMux_Out), 64'd0);

        loadIn(32'h0000_03FF);
        Bus_Src = SWB'(SRC_IN); MAR_In = 1'b1; OutPort_In = 1'b1; HI_In = 1'b1; tick();
        MAR_In = 1'b0; OutPort_In = 1'b0; HI_In = 1'b0;
        checkOutput("mar_trunc", 64'(MAR_Data), 64'h1FF);
        checkOutput("outport", 64'(Output_Data), 64'h3FF);
        Bus_Src = SWB'(SRC_HI); #1;
        checkOutput("hi_load", 64'(BusMux_Out), 64'h3FF);
        RAM_Data = 32'hABCD_0123; Read = 1'b1; MDR_In = 1'b1; tick();
        checkOutput("mdr_read", 64'(MDR_Data), 64'hABCD_0123);
        Read = 1'b0; Bus_Src = SWB'(SRC_IN); tick(); MDR_In = 1'b0;
        checkOutput("mdr_bus", 64'(MDR_Data), 64'h3FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
